// File: rtl/rsa_job_arbiter_pkg.sv
// Purpose: shared types and helpers for the rsa_unit job arbiter.
//   state_e       : job sequencer states (IDLE, GRANT, RUN, COMPLETE)
//   wd_width()    : watchdog counter width for a given timeout, never below 1
package rsa_job_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_RUN      = 2'd2,
    ST_COMPLETE = 2'd3
  } state_e;

  function automatic int wd_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rsa_job_arbiter_if.sv
// Purpose: bundles the requester/rsa_unit side signals of the job arbiter.
//   ena, req, abort, eoc_rsa, irq_clr         : driven by the environment (master)
//   gnt, busy, en_rsa, clear_rsa, done, err,
//   irq, state                                : driven by the arbiter (slave)
// Handshake: a requester holds req high until it sees gnt; the job ends with a
// single-cycle done (plus err on timeout) or silently when abort is honoured.
// state is a read-only debug view of the sequencer.
interface rsa_job_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import rsa_job_arbiter_pkg::*;

  logic               ena;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] abort;
  logic               eoc_rsa;
  logic               irq_clr;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               en_rsa;
  logic               clear_rsa;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic               irq;
  state_e             state;

  modport master (
    output ena, req, abort, eoc_rsa, irq_clr,
    input  gnt, busy, en_rsa, clear_rsa, done, err, irq, state
  );

  modport slave (
    input  ena, req, abort, eoc_rsa, irq_clr,
    output gnt, busy, en_rsa, clear_rsa, done, err, irq, state
  );

endinterface

// File: rtl/rsa_job_arbiter_rr_arbiter.sv
// Purpose: round-robin winner select plus rotating priority pointer.
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   req_i    : request vector
//   upd_i    : grant strobe; pointer moves to one past the current winner
//   win_o    : one-hot winner (zero when no request)
//   any_o    : at least one request present
module rsa_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               any_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          found;

  // Scan starting at the pointer and wrapping; the first hit wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_o = found ? (NUM_REQ'(1) << win_idx) : '0;
  end

  assign any_o = |req_i;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Purpose: shares one rsa_unit among NUM_REQ requesters. Grants round-robin,
// sequences clear/run/complete, and ends hung jobs via a watchdog with err.
//   clk, rst : clock, async active-high reset (abandons any job, no done)
//   bus      : rsa_job_arbiter_if slave side (see interface header)
module rsa_job_arbiter
  import rsa_job_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic              clk,
  input logic              rst,
  rsa_job_arbiter_if.slave bus
);

  localparam int WW = wd_width(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               to_q, to_d;
  logic               irq_q, irq_d;

  logic [NUM_REQ-1:0] win;
  logic               any_req;
  logic               grant_upd;

  logic [NUM_REQ-1:0] gnt_c, done_c, err_c;
  logic               en_c, clr_c;

  // The pointer only moves on a real grant, so a frozen clock enable also
  // freezes arbitration.
  assign grant_upd = bus.ena && (state_q == ST_IDLE) && any_req;

  rsa_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.req),
    .upd_i (grant_upd),
    .win_o (win),
    .any_o (any_req)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    to_d    = to_q;
    irq_d   = irq_q & ~bus.irq_clr;
    gnt_c   = '0;
    done_c  = '0;
    err_c   = '0;
    en_c    = 1'b0;
    clr_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = win;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        gnt_c   = owner_q;
        en_c    = 1'b1;
        wd_d    = '0;
        to_d    = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        gnt_c = owner_q;
        en_c  = 1'b1;
        clr_c = 1'b1;
        wd_d  = wd_q + WW'(1);
        // eoc beats abort beats watchdog.
        if (bus.eoc_rsa) begin
          to_d    = 1'b0;
          state_d = ST_COMPLETE;
        end else if (|(bus.abort & owner_q)) begin
          state_d = ST_IDLE;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        gnt_c   = owner_q;
        en_c    = 1'b1;
        clr_c   = 1'b1;
        done_c  = owner_q;
        err_c   = to_q ? owner_q : '0;
        irq_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else if (bus.ena) begin
      state_q <= state_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.en_rsa    = en_c;
  assign bus.clear_rsa = clr_c;
  assign bus.done      = done_c;
  assign bus.err       = err_c;
  // irq is visible in the same cycle as done, then held by irq_q.
  assign bus.irq       = irq_q | (state_q == ST_COMPLETE);
  assign bus.state     = state_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));

endmodule

// File: tb/tb_rsa_job_arbiter.sv
module tb_rsa_job_arbiter;
  import rsa_job_arbiter_pkg::*;

  localparam int N = 2;
  localparam int T = 16;

  localparam int M_EOC     = 0;
  localparam int M_ABORT   = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_BOTH    = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsa_job_arbiter_if #(.NUM_REQ(N)) bus ();

  rsa_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard / reference state
  int           n_cmp = 0;
  int           n_err = 0;
  int           ptr_m;
  logic         irq_m;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] gnt, input logic busy,
                            input logic en, input logic clr, input logic [N-1:0] done,
                            input logic [N-1:0] err, input logic irq);
    check({tag, ".gnt"},    32'(bus.gnt), 32'(gnt));
    check({tag, ".busy"},   32'(bus.busy), 32'(busy));
    check({tag, ".en"},     32'(bus.en_rsa), 32'(en));
    check({tag, ".clear"},  32'(bus.clear_rsa), 32'(clr));
    check({tag, ".done"},   32'(bus.done), 32'(done));
    check({tag, ".err"},    32'(bus.err), 32'(err));
    check({tag, ".irq"},    32'(bus.irq), 32'(irq));
    check({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] rq);
    for (int k = 0; k < N; k++) begin
      if (rq[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  // One whole job from IDLE back to IDLE. k = RUN cycle (1-based) on which eoc
  // and/or abort is driven; a timeout job ends after T RUN cycles.
  task automatic do_job(input string tag, input logic [N-1:0] rq, input int mode, input int k,
                        input int freeze_at, input bit clr_in_complete, input bit clr_after);
    int           w;
    logic [N-1:0] own;
    logic [N-1:0] exp_done;
    check({tag, ".pre_idle"}, 32'(bus.busy), 32'd0);
    w   = pick(rq);
    own = N'(1) << w;
    ptr_m = (w + 1) % N;
    if (mode != M_ABORT) exp_q.push_back(own);
    bus.req = rq;
    step();
    bus.req = N'($urandom);
    expect_out({tag, ".grant"}, own, 1'b1, 1'b1, 1'b0, '0, '0, irq_m);
    for (int c = 1; c <= T; c++) begin
      step();
      expect_out({tag, ".run"}, own, 1'b1, 1'b1, 1'b1, '0, '0, irq_m);
      if (c == freeze_at) begin
        bus.ena     = 1'b0;
        bus.eoc_rsa = 1'b1;
        bus.abort   = own;
        bus.irq_clr = 1'b1;
        repeat (4) begin
          step();
          expect_out({tag, ".frozen"}, own, 1'b1, 1'b1, 1'b1, '0, '0, irq_m);
        end
        bus.ena     = 1'b1;
        bus.irq_clr = 1'b0;
      end
      bus.abort   = N'($urandom) & ~own;
      bus.eoc_rsa = 1'b0;
      if (c == k && (mode == M_EOC || mode == M_BOTH)) bus.eoc_rsa = 1'b1;
      if (c == k && (mode == M_ABORT || mode == M_BOTH)) bus.abort = bus.abort | own;
      if (c == k && mode != M_TIMEOUT) break;
    end
    step();
    bus.eoc_rsa = 1'b0;
    bus.abort   = '0;
    bus.req     = '0;
    if (mode == M_ABORT) begin
      expect_out({tag, ".aborted"}, '0, 1'b0, 1'b0, 1'b0, '0, '0, irq_m);
    end else begin
      exp_done = exp_q.pop_front();
      irq_m    = 1'b1;
      expect_out({tag, ".complete"}, own, 1'b1, 1'b1, 1'b1, exp_done,
                 (mode == M_TIMEOUT) ? own : '0, 1'b1);
      bus.irq_clr = clr_in_complete;
      step();
      bus.irq_clr = 1'b0;
      expect_out({tag, ".idle"}, '0, 1'b0, 1'b0, 1'b0, '0, '0, irq_m);
    end
    if (clr_after) begin
      bus.irq_clr = 1'b1;
      step();
      bus.irq_clr = 1'b0;
      irq_m = 1'b0;
      expect_out({tag, ".irq_clr"}, '0, 1'b0, 1'b0, 1'b0, '0, '0, irq_m);
    end
  endtask

  initial begin
    int mode;
    int k;
    int fz;
    logic [N-1:0] rq;

    rst         = 1'b1;
    bus.ena     = 1'b1;
    bus.req     = '0;
    bus.abort   = '0;
    bus.eoc_rsa = 1'b0;
    bus.irq_clr = 1'b0;
    ptr_m       = 0;
    irq_m       = 1'b0;
    step();
    step();
    expect_out("reset", '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check("reset.state", 32'(bus.state), 32'(ST_IDLE));
    rst = 1'b0;
    step();
    expect_out("post_reset", '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // single job, eoc after a few RUN cycles
    do_job("basic", 2'b01, M_EOC, 4, 0, 1'b0, 1'b1);
    // both requesting: grants must alternate
    do_job("rr_a", 2'b11, M_EOC, 2, 0, 1'b0, 1'b0);
    do_job("rr_b", 2'b11, M_EOC, 1, 0, 1'b0, 1'b0);
    do_job("rr_c", 2'b11, M_EOC, 3, 0, 1'b0, 1'b1);
    // watchdog then a clean job
    do_job("timeout", 2'b10, M_TIMEOUT, 0, 0, 1'b0, 1'b0);
    do_job("after_to", 2'b10, M_EOC, 2, 0, 1'b0, 1'b0);
    // abort by owner keeps irq untouched
    do_job("abort", 2'b01, M_ABORT, 3, 0, 1'b0, 1'b0);
    // eoc wins over abort; clear during COMPLETE loses to set
    do_job("eoc_abort", 2'b01, M_BOTH, 2, 0, 1'b1, 1'b1);
    // eoc on the last possible RUN cycle wins over the watchdog
    do_job("eoc_edge", 2'b10, M_EOC, T, 0, 1'b0, 1'b0);
    // clock enable freeze mid-RUN, watchdog must not advance
    do_job("freeze_to", 2'b01, M_TIMEOUT, 0, 5, 1'b0, 1'b0);
    do_job("freeze_eoc", 2'b11, M_EOC, 3, 3, 1'b0, 1'b1);

    // randomized jobs
    for (int j = 0; j < 30; j++) begin
      rq   = N'($urandom_range(1, 3));
      mode = $urandom_range(0, 3);
      k    = $urandom_range(1, T);
      fz   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      do_job("rand", rq, mode, k, fz, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // async reset mid-RUN abandons the job with no done
    bus.req = 2'b01;
    step();
    bus.req = '0;
    step();
    step();
    check("pre_rst.busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check("async_rst.state", 32'(bus.state), 32'(ST_IDLE));
    step();
    rst   = 1'b0;
    ptr_m = 0;
    irq_m = 1'b0;
    repeat (3) begin
      step();
      expect_out("after_rst", '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    // pointer restarted at 0 after reset
    do_job("post_rst_job", 2'b11, M_EOC, 2, 0, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
